// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Function : Round-robin share of one valid/ready memory slave port between
//             two requesters, with a watchdog that answers with an error word.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        owner,
    output logic        timeout_err
);

    localparam int unsigned c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_last_grant;
    logic               r_owner;
    logic               r_s_valid;
    logic               r_s_instr;
    logic [31:0]        r_s_addr;
    logic [31:0]        r_s_wdata;
    logic [3:0]         r_s_wstrb;
    logic               r_m0_ready;
    logic               r_m1_ready;
    logic [31:0]        r_m0_rdata;
    logic [31:0]        r_m1_rdata;
    logic               r_timeout_err;

    logic               w_req;
    logic               w_grant;
    logic               w_timeout;
    logic [31:0]        w_resp_data;

    assign w_req   = m0_valid | m1_valid;
    // Contention goes to whoever was not served last; otherwise the lone requester wins.
    assign w_grant = (m0_valid & m1_valid) ? ~r_last_grant : m1_valid;

    generate
        if (TIMEOUT != 0) begin : g_timeout
            assign w_timeout = (r_cnt == c_cnt_last);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // Slave completion takes precedence over a simultaneous watchdog expiry.
    assign w_resp_data = s_ready ? s_rdata : ERR_DATA;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_next = S_BUSY;
            S_BUSY:  if (s_ready || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt         <= '0;
            r_last_grant  <= 1'b1;
            r_owner       <= 1'b0;
            r_s_valid     <= 1'b0;
            r_s_instr     <= 1'b0;
            r_s_addr      <= '0;
            r_s_wdata     <= '0;
            r_s_wstrb     <= '0;
            r_m0_ready    <= 1'b0;
            r_m1_ready    <= 1'b0;
            r_m0_rdata    <= '0;
            r_m1_rdata    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_m0_ready    <= 1'b0;
            r_m1_ready    <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_s_valid    <= 1'b1;
                        r_s_instr    <= w_grant ? m1_instr : m0_instr;
                        r_s_addr     <= w_grant ? m1_addr  : m0_addr;
                        r_s_wdata    <= w_grant ? m1_wdata : m0_wdata;
                        r_s_wstrb    <= w_grant ? m1_wstrb : m0_wstrb;
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_cnt        <= '0;
                    end
                end
                S_BUSY: begin
                    if (s_ready || w_timeout) begin
                        r_s_valid     <= 1'b0;
                        r_timeout_err <= ~s_ready;
                        if (r_owner) begin
                            r_m1_rdata <= w_resp_data;
                            r_m1_ready <= 1'b1;
                        end else begin
                            r_m0_rdata <= w_resp_data;
                            r_m0_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_valid     = r_s_valid;
    assign s_instr     = r_s_instr;
    assign s_addr      = r_s_addr;
    assign s_wdata     = r_s_wdata;
    assign s_wstrb     = r_s_wstrb;
    assign m0_ready    = r_m0_ready;
    assign m1_ready    = r_m1_ready;
    assign m0_rdata    = r_m0_rdata;
    assign m1_rdata    = r_m1_rdata;
    assign owner       = r_owner;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
